regfile_wb_sequencer: RTL

REGFILE_WB_SEQUENCER -- requirements
Module: regfile_wb_sequencer

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_wb_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, state type and helpers for the register-file write-back sequencer.
package regfile_pkg;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam int         NUM_REGS = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_E = 2'd1,
    ST_WR_M = 2'd2
  } wb_state_e;

  // Entry state for a freshly accepted request; IDLE means nothing to write.
  function automatic wb_state_e first_state(input logic [3:0] dst_e, input logic [3:0] dst_m);
    if (dst_e != REG_NONE)      return ST_WR_E;
    else if (dst_m != REG_NONE) return ST_WR_M;
    else                        return ST_IDLE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with one set vector, one clear index and two hazard query ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NUM_REGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREG-1:0] set_vec,
  input  logic            clr_en,
  input  logic [3:0]      clr_idx,
  input  logic [3:0]      qa_idx,
  input  logic [3:0]      qb_idx,
  output logic            qa_hit,
  output logic            qb_hit
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [15:0]     clr_mask;
  logic [15:0]     pend_pad;

  // Set wins over clear so a back-to-back request reusing the retiring register stays pending.
  always_comb begin
    clr_mask  = 16'(clr_en) << clr_idx;
    pending_d = (pending_q & ~clr_mask[NREG-1:0]) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Padding keeps IDs at or above NREG (including RNONE) reading as not pending.
  always_comb begin
    pend_pad = 16'(pending_q);
    qa_hit   = (qa_idx != REG_NONE) && pend_pad[qa_idx];
    qb_hit   = (qb_idx != REG_NONE) && pend_pad[qb_idx];
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Serialises a dual-destination (E then M) write-back onto a single register-file write port.
// Optional macro WB_SEQ_PIPELINE_EN: accept the next request in the last write state (no idle gap).
//
// state   | meaning
// IDLE    | no write in flight, ready for a request
// WR_E    | writing latched ALU result (dstE/valE)
// WR_M    | writing latched memory result (dstM/valM)
module regfile_wb_sequencer
  import regfile_pkg::*;
#(
  parameter int DW   = 64,
  parameter int NREG = NUM_REGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [3:0]    dstE,
  input  logic [DW-1:0] valE,
  input  logic [3:0]    dstM,
  input  logic [DW-1:0] valM,
  input  logic [3:0]    srcA,
  input  logic [3:0]    srcB,
  output logic          hazA,
  output logic          hazB,
  output logic          wr_en,
  output logic [3:0]    wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
);

  wb_state_e       state_q, state_d;
  logic [3:0]      dst_e_q, dst_e_d;
  logic [3:0]      dst_m_q, dst_m_d;
  logic [DW-1:0]   val_e_q, val_e_d;
  logic [DW-1:0]   val_m_q, val_m_d;
  logic            accept;
  logic            last_wr;
  logic [15:0]     set_pad;
  logic [NREG-1:0] set_vec;
  logic            clr_en;
  logic [3:0]      clr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dst_e_q <= REG_NONE;
      dst_m_q <= REG_NONE;
      val_e_q <= '0;
      val_m_q <= '0;
    end else begin
      state_q <= state_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
      val_e_q <= val_e_d;
      val_m_q <= val_m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dst_e_d = dst_e_q;
    dst_m_d = dst_m_q;
    val_e_d = val_e_q;
    val_m_d = val_m_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WR_E: state_d = (dst_m_q != REG_NONE) ? ST_WR_M : ST_IDLE;
      ST_WR_M: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = first_state(dstE, dstM);
      dst_e_d = dstE;
      dst_m_d = dstM;
      val_e_d = valE;
      val_m_d = valM;
    end
  end

  always_comb begin
    last_wr = (state_q == ST_WR_M) || ((state_q == ST_WR_E) && (dst_m_q == REG_NONE));
`ifdef WB_SEQ_PIPELINE_EN
    wb_ready = (state_q == ST_IDLE) || last_wr;
`else
    wb_ready = (state_q == ST_IDLE);
`endif
    accept  = wb_valid && wb_ready;
    busy    = (state_q != ST_IDLE);
    wr_en   = 1'b0;
    wr_addr = REG_NONE;
    wr_data = '0;
    clr_en  = 1'b0;
    clr_idx = REG_NONE;
    case (state_q)
      ST_WR_E: begin
        wr_en   = 1'b1;
        wr_addr = dst_e_q;
        wr_data = val_e_q;
        // With dstE == dstM the bit must survive until the M write retires.
        clr_en  = (dst_e_q != dst_m_q);
        clr_idx = dst_e_q;
      end
      ST_WR_M: begin
        wr_en   = 1'b1;
        wr_addr = dst_m_q;
        wr_data = val_m_q;
        clr_en  = 1'b1;
        clr_idx = dst_m_q;
      end
      default: ;
    endcase
    set_pad = '0;
    if (accept) begin
      if (dstE != REG_NONE) set_pad[dstE] = 1'b1;
      if (dstM != REG_NONE) set_pad[dstM] = 1'b1;
    end
    set_vec = set_pad[NREG-1:0];
  end

  regfile_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_vec (set_vec),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .qa_idx  (srcA),
    .qb_idx  (srcB),
    .qa_hit  (hazA),
    .qb_hit  (hazB)
  );

endmodule
